// File: rtl/rv64g_l1_vlsu_bank_sched_pkg.sv
// Shared constants and types for the L1 vector load/store bank scheduler.
// Holds the lane/bank geometry, the bank-field position and the scheduler state encoding.
package rv64g_l1_vlsu_bank_sched_pkg;

   localparam int unsigned DEF_NUM_LANES = 8;
   localparam int unsigned DEF_NUM_BANKS = 8;
   localparam int unsigned ADDR_W        = 64;
   localparam int unsigned BANK_LSB      = 3;
   localparam int unsigned BANK_W        = 3;
   localparam int unsigned WORD_W        = ADDR_W - BANK_LSB;
   localparam int unsigned LANE_IDX_W    = 3;
   localparam int unsigned BEAT_W        = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } sched_state_e;

   localparam logic [1:0] MESI_I = 2'd0;
   localparam logic [1:0] MESI_S = 2'd1;
   localparam logic [1:0] MESI_E = 2'd2;
   localparam logic [1:0] MESI_M = 2'd3;

endpackage

// File: rtl/rv64g_l1_vlsu_bank_sched_arb.sv
// Per-bank pick: lowest pending lane mapping to this bank wins, and every pending
// lane hitting the same 8-byte word as the winner rides along in the same beat.
module rv64g_l1_vlsu_bank_arb
   import rv64g_l1_vlsu_bank_sched_pkg::*;
#(
   parameter int unsigned NUM_LANES = DEF_NUM_LANES,
   parameter int unsigned BANK_IDX  = 0
) (
   input  logic [NUM_LANES-1:0]        pending_i,
   input  logic [NUM_LANES*WORD_W-1:0] word_i,
   output logic [NUM_LANES-1:0]        grant_o,
   output logic [LANE_IDX_W-1:0]       src_lane_o,
   output logic                        active_o
);

   logic              found;
   logic [WORD_W-1:0] win_word;

   // word_i is addr[63:3], so its low BANK_W bits are the bank field
   always_comb begin
      found      = 1'b0;
      src_lane_o = '0;
      win_word   = '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
         if (!found && pending_i[i] &&
             word_i[i*WORD_W +: BANK_W] == BANK_W'(BANK_IDX)) begin
            found      = 1'b1;
            src_lane_o = LANE_IDX_W'(i);
            win_word   = word_i[i*WORD_W +: WORD_W];
         end
      end
      grant_o = '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
         grant_o[i] = found && pending_i[i] && (word_i[i*WORD_W +: WORD_W] == win_word);
      end
      active_o = found;
   end

endmodule

// File: rtl/rv64g_l1_vlsu_bank_sched.sv
// Vector LSU bank scheduler: latches a multi-lane request and issues it to the
// hit-detect stage in beats of bank-conflict-free (and word-coalesced) lanes.
module rv64g_l1_vlsu_bank_sched
   import rv64g_l1_vlsu_bank_sched_pkg::*;
#(
   parameter int unsigned NUM_LANES = DEF_NUM_LANES,
   parameter int unsigned NUM_BANKS = DEF_NUM_BANKS,
   parameter int unsigned ID_W      = 3
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      req_valid_i,
   output logic                      req_ready_o,
   input  logic [NUM_LANES*64-1:0]   req_addr_i,
   input  logic [NUM_LANES-1:0]      req_mask_i,
   input  logic [ID_W-1:0]           req_id_i,
   input  logic                      flush_i,
   output logic [NUM_LANES*64-1:0]   lane_addr_o,
   output logic [NUM_LANES-1:0]      lane_valid_o,
   output logic [NUM_BANKS*3-1:0]    bank_src_lane_o,
   output logic [NUM_BANKS-1:0]      bank_active_o,
   output logic                      issue_valid_o,
   input  logic                      issue_ready_i,
   output logic                      issue_last_o,
   output logic [ID_W-1:0]           issue_id_o,
   output logic [BEAT_W-1:0]         issue_beat_o
);

   sched_state_e                state_q, state_d;
   logic [NUM_LANES-1:0]        pend_q, pend_d;
   logic [NUM_LANES*64-1:0]     addr_q, addr_d;
   logic [ID_W-1:0]             id_q, id_d;
   logic [BEAT_W-1:0]           beat_q, beat_d;

   logic [NUM_LANES*WORD_W-1:0] word;
   logic [NUM_LANES-1:0]        bank_grant [NUM_BANKS];
   logic [LANE_IDX_W-1:0]       bank_src   [NUM_BANKS];
   logic [NUM_BANKS-1:0]        bank_act;
   logic [NUM_LANES-1:0]        grant;
   logic                        issuing;
   logic                        last;

   always_comb begin
      word = '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
         word[i*WORD_W +: WORD_W] = addr_q[i*64 + BANK_LSB +: WORD_W];
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      rv64g_l1_vlsu_bank_arb #(
         .NUM_LANES (NUM_LANES),
         .BANK_IDX  (b)
      ) u_arb (
         .pending_i  (pend_q),
         .word_i     (word),
         .grant_o    (bank_grant[b]),
         .src_lane_o (bank_src[b]),
         .active_o   (bank_act[b])
      );
   end

   // Banks partition the lanes, so per-bank grants never overlap
   always_comb begin
      grant           = '0;
      bank_src_lane_o = '0;
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
         grant = grant | bank_grant[b];
         if (issuing) bank_src_lane_o[b*3 +: 3] = bank_src[b];
      end
   end

   assign issuing       = (state_q == ISSUE);
   assign last          = issuing && ((pend_q & ~grant) == '0);
   assign req_ready_o   = (state_q == IDLE);
   assign issue_valid_o = issuing;
   assign issue_last_o  = last;
   assign issue_id_o    = id_q;
   assign issue_beat_o  = beat_q;
   assign lane_addr_o   = addr_q;
   assign lane_valid_o  = issuing ? grant : '0;
   assign bank_active_o = issuing ? bank_act : '0;

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      addr_d  = addr_q;
      id_d    = id_q;
      beat_d  = beat_q;
      if (flush_i) begin
         state_d = IDLE;
         pend_d  = '0;
      end else if (state_q == IDLE) begin
         if (req_valid_i) begin
            addr_d  = req_addr_i;
            id_d    = req_id_i;
            pend_d  = req_mask_i;
            beat_d  = '0;
            state_d = (|req_mask_i) ? ISSUE : IDLE;
         end
      end else if (issue_ready_i) begin
         pend_d = pend_q & ~grant;
         if (last) state_d = IDLE;
         else      beat_d  = beat_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pend_q  <= '0;
         addr_q  <= '0;
         id_q    <= '0;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         addr_q  <= addr_d;
         id_q    <= id_d;
         beat_q  <= beat_d;
      end
   end

endmodule
